// File: rtl/llsc_reservation_monitor.sv
// Shared LL/SC exclusive-reservation monitor for an N-core cluster.
// Round-robin serialises LL/SC/ST traffic; snoops and an idle timer kill reservations.
module llsc_reservation_monitor #(
  parameter int N_CORES      = 4,
  parameter int ADDR_WIDTH   = 32,
  parameter int GRANULE_LOG2 = 5,
  parameter int TIMEOUT      = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_CORES-1:0]            req_valid,
  input  logic [2*N_CORES-1:0]          req_op,
  input  logic [N_CORES*ADDR_WIDTH-1:0] req_addr,
  output logic [N_CORES-1:0]            req_ready,
  output logic [N_CORES-1:0]            resp_valid,
  output logic                          resp_sc_ok,
  input  logic                          snoop_valid,
  input  logic [ADDR_WIDTH-1:0]         snoop_addr,
  output logic [N_CORES-1:0]            res_valid_o
);

  localparam int TW = ADDR_WIDTH - GRANULE_LOG2;
  localparam int PW = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  localparam int LW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [LW-1:0] LIFE_INIT = LW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  localparam logic [1:0] OP_LL = 2'b00;
  localparam logic [1:0] OP_SC = 2'b01;

  logic [N_CORES-1:0] res_valid_q, res_valid_d, valid_mid;
  logic [TW-1:0]      res_tag_q [N_CORES];
  logic [TW-1:0]      res_tag_d [N_CORES];
  // Remaining life of each reservation; expires when it reaches zero.
  logic [LW-1:0]      life_q [N_CORES];
  logic [LW-1:0]      life_d [N_CORES];
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [N_CORES-1:0] resp_valid_q, resp_valid_d;
  logic               resp_sc_ok_q, resp_sc_ok_d;

  logic [N_CORES-1:0]    grant;
  logic [PW-1:0]         gnt_idx;
  logic                  found;
  int                    cand;
  logic                  gnt;
  logic [1:0]            g_op;
  logic [ADDR_WIDTH-1:0] g_addr;
  logic [TW-1:0]         g_tag, snoop_tag;
  logic                  sc_ok, resp_ok;
  logic                  unused_low_bits;

  always_comb begin
    grant   = '0;
    gnt_idx = ptr_q;
    found   = 1'b0;
    cand    = 0;
    for (int k = 1; k <= N_CORES; k++) begin
      cand = (int'(ptr_q) + k) % N_CORES;
      if (!found && req_valid[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        gnt_idx     = PW'(cand);
      end
    end
  end

  // A grant during reset would be dropped, so it is not advertised either.
  assign req_ready = rst ? '0 : grant;
  assign gnt       = found && !rst;

  assign g_op      = req_op[2*gnt_idx +: 2];
  assign g_addr    = req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign g_tag     = g_addr[ADDR_WIDTH-1:GRANULE_LOG2];
  assign snoop_tag = snoop_addr[ADDR_WIDTH-1:GRANULE_LOG2];
  assign unused_low_bits = ^{g_addr[GRANULE_LOG2-1:0], snoop_addr[GRANULE_LOG2-1:0]};

  always_comb begin
    valid_mid = res_valid_q;
    for (int i = 0; i < N_CORES; i++) begin
      if (snoop_valid && res_tag_q[i] == snoop_tag) valid_mid[i] = 1'b0;
      if (TIMEOUT > 0 && res_valid_q[i] && life_q[i] == '0) valid_mid[i] = 1'b0;
    end

    // SC sees the state after this cycle's snoop and expiry have been applied.
    sc_ok       = valid_mid[gnt_idx] && (res_tag_q[gnt_idx] == g_tag);
    res_valid_d = valid_mid;
    resp_ok     = 1'b1;
    for (int i = 0; i < N_CORES; i++) begin
      res_tag_d[i] = res_tag_q[i];
      life_d[i]    = (res_valid_q[i] && life_q[i] != '0) ? life_q[i] - 1'b1 : life_q[i];
    end

    if (gnt) begin
      case (g_op)
        OP_LL: begin
          if (snoop_valid && snoop_tag == g_tag) begin
            res_valid_d[gnt_idx] = 1'b0;
          end else begin
            res_valid_d[gnt_idx] = 1'b1;
            res_tag_d[gnt_idx]   = g_tag;
            life_d[gnt_idx]      = LIFE_INIT;
          end
        end
        OP_SC: begin
          resp_ok = sc_ok;
          if (sc_ok) begin
            for (int i = 0; i < N_CORES; i++)
              if (res_tag_q[i] == g_tag) res_valid_d[i] = 1'b0;
          end else begin
            res_valid_d[gnt_idx] = 1'b0;
          end
        end
        default: begin
          for (int i = 0; i < N_CORES; i++)
            if (res_tag_q[i] == g_tag) res_valid_d[i] = 1'b0;
        end
      endcase
    end

    ptr_d        = gnt ? gnt_idx : ptr_q;
    resp_valid_d = gnt ? grant : '0;
    resp_sc_ok_d = gnt ? resp_ok : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid_q  <= '0;
      ptr_q        <= PW'(N_CORES - 1);
      resp_valid_q <= '0;
      resp_sc_ok_q <= 1'b0;
      for (int i = 0; i < N_CORES; i++) begin
        res_tag_q[i] <= '0;
        life_q[i]    <= '0;
      end
    end else begin
      res_valid_q  <= res_valid_d;
      ptr_q        <= ptr_d;
      resp_valid_q <= resp_valid_d;
      resp_sc_ok_q <= resp_sc_ok_d;
      for (int i = 0; i < N_CORES; i++) begin
        res_tag_q[i] <= res_tag_d[i];
        life_q[i]    <= life_d[i];
      end
    end
  end

  assign resp_valid  = resp_valid_q;
  assign resp_sc_ok  = resp_sc_ok_q;
  assign res_valid_o = res_valid_q;

endmodule
